// File: rtl/duc_dac_pkg.sv
// Shared encodings and the sample reduction helper for the DUC-to-DAC bridge.
package duc_dac_pkg;

  typedef enum logic [1:0] {
    MODE_DUC   = 2'd0,
    MODE_CONST = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_ZERO  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Round half-up, arithmetic shift to out_w bits, saturate, optional MSB invert.
  // Caller sign-extends the sample to 32 bits and keeps the low out_w bits of the result.
  function automatic logic [31:0] fmt_sample(input logic signed [31:0] smp,
                                             input logic              offset_bin,
                                             input int unsigned       in_w,
                                             input int unsigned       out_w);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic        [31:0] res;
    r  = (smp + (32'sd1 <<< (in_w - out_w - 1))) >>> (in_w - out_w);
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    res = r;
    res = res & ((32'd1 << out_w) - 32'd1);
    if (offset_bin) begin
      res[out_w-1] = ~res[out_w-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/dd_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush and occupancy count.
module dd_sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_out1,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] LvlFull = DEPTH[AddrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AddrW:0]   level_q, level_d;
  logic             do_wr, do_rd;

  assign full    = (level_q == LvlFull);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rptr_q];
  assign do_rd   = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign do_wr   = wr_en & (~full | do_rd);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + 1'b1;
      if (do_rd) rptr_d = rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_out1 or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_out1) begin
    if (do_wr && !flush) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/duc_dac_bridge.sv
// DUC to Pmod DAC bridge: sample-rate clock enable, sample FIFO, width reduction and
// test-pattern generation, all in the clk_out1 domain.
module duc_dac_bridge
  import duc_dac_pkg::*;
#(
  parameter int unsigned           IN_W       = 18,
  parameter int unsigned           OUT_W      = 16,
  parameter int unsigned           DIV        = 4,
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter int unsigned           PRIME_LVL  = 4,
  parameter logic [OUT_W-1:0]      CONST_RE   = 16'sh2000,
  parameter logic [OUT_W-1:0]      CONST_IM   = 16'sh0000
) (
  input  logic                          clk_out1,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic                          offset_bin,
  input  logic                          clear_flags,
  output logic                          duc_ce,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_re,
  input  logic [IN_W-1:0]               in_im,
  output logic                          dac_valid,
  output logic [OUT_W-1:0]              dac_re,
  output logic [OUT_W-1:0]              dac_im,
  output logic                          underflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              duc_ce_q, duc_ce_d;
  logic [OUT_W-1:0]  ramp_q, ramp_d;
  logic [OUT_W-1:0]  re_q, re_d, im_q, im_d;
  logic              valid_q, valid_d;
  logic              unf_q, unf_d, ovf_q, ovf_d;

  mode_e             mode_sel;
  logic              play_tick, run_tick, flush, pop, wr_en, unf_set, ovf_set;
  logic              full, empty;
  logic [LvlW-1:0]   level;
  logic [2*IN_W-1:0] rd_data;
  logic signed [IN_W-1:0] rd_re, rd_im;
  logic signed [31:0] ext_re, ext_im;
  logic [OUT_W-1:0]  fmt_re, fmt_im;

  assign mode_sel  = mode_e'(mode);
  assign play_tick = (cnt_q == '0);
  assign run_tick  = (state_q == RUN) & enable & play_tick;
  assign flush     = (state_q == IDLE) | ~enable;
  assign pop       = run_tick & (mode_sel == MODE_DUC) & ~empty;
  assign in_ready  = ~full | pop;
  assign wr_en     = in_valid & in_ready & ~flush;
  assign ovf_set   = in_valid & ~in_ready & ~flush;

  dd_sync_fifo #(
    .WIDTH (2 * IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_out1 (clk_out1),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  ({in_re, in_im}),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign rd_re  = rd_data[2*IN_W-1:IN_W];
  assign rd_im  = rd_data[IN_W-1:0];
  assign ext_re = 32'(rd_re);
  assign ext_im = 32'(rd_im);
  // Stored words stay two's complement; offset binary is applied at the pins.
  assign fmt_re = OUT_W'(fmt_sample(ext_re, 1'b0, IN_W, OUT_W));
  assign fmt_im = OUT_W'(fmt_sample(ext_im, 1'b0, IN_W, OUT_W));

  always_comb begin
    cnt_d    = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    duc_ce_d = (cnt_q == CntMax);
    state_d  = state_q;
    ramp_d   = ramp_q;
    re_d     = re_q;
    im_d     = im_q;
    valid_d  = 1'b0;
    unf_set  = 1'b0;

    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (level >= LvlW'(PRIME_LVL) || mode_sel != MODE_DUC) begin
          state_d = RUN;
        end
      end
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (run_tick) begin
      valid_d = 1'b1;
      unique case (mode_sel)
        MODE_DUC: begin
          if (!empty) begin
            re_d = fmt_re;
            im_d = fmt_im;
          end else begin
            re_d    = '0;
            im_d    = '0;
            unf_set = 1'b1;
          end
        end
        MODE_CONST: begin
          re_d = CONST_RE;
          im_d = CONST_IM;
        end
        MODE_RAMP: begin
          re_d   = ramp_q;
          im_d   = ~ramp_q;
          ramp_d = ramp_q + 1'b1;
        end
        MODE_ZERO: begin
          re_d = '0;
          im_d = '0;
        end
      endcase
    end

    if (!enable) ramp_d = '0;

    unf_d = (unf_q & ~clear_flags) | unf_set;
    ovf_d = (ovf_q & ~clear_flags) | ovf_set;
  end

  always_ff @(posedge clk_out1 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      duc_ce_q <= 1'b0;
      ramp_q   <= '0;
      re_q     <= '0;
      im_q     <= '0;
      valid_q  <= 1'b0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duc_ce_q <= duc_ce_d;
      ramp_q   <= ramp_d;
      re_q     <= re_d;
      im_q     <= im_d;
      valid_q  <= valid_d;
      unf_q    <= unf_d;
      ovf_q    <= ovf_d;
    end
  end

  assign duc_ce     = duc_ce_q;
  assign dac_valid  = valid_q;
  assign dac_re     = re_q ^ {offset_bin, {(OUT_W-1){1'b0}}};
  assign dac_im     = im_q ^ {offset_bin, {(OUT_W-1){1'b0}}};
  assign underflow  = unf_q;
  assign overflow   = ovf_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_duc_dac_bridge.sv
// Bench for duc_dac_bridge: directed scenarios plus random traffic against a queue-based model.
module tb_duc_dac_bridge;
  localparam int unsigned IN_W  = 18;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PLVL  = 4;
  localparam int PhIdle = 0, PhPrime = 1, PhRun = 2;

  logic             clk_out1 = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             offset_bin = 1'b0;
  logic             clear_flags = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_re = '0;
  logic [IN_W-1:0]  in_im = '0;
  logic             duc_ce, in_ready, dac_valid, underflow, overflow;
  logic [OUT_W-1:0] dac_re, dac_im;
  logic [3:0]       fifo_level;

  duc_dac_bridge #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .DIV        (DIV),
    .FIFO_DEPTH (DEPTH),
    .PRIME_LVL  (PLVL),
    .CONST_RE   (16'sh2000),
    .CONST_IM   (16'sh0000)
  ) dut (
    .clk_out1    (clk_out1),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .offset_bin  (offset_bin),
    .clear_flags (clear_flags),
    .duc_ce      (duc_ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .dac_valid   (dac_valid),
    .dac_re      (dac_re),
    .dac_im      (dac_im),
    .underflow   (underflow),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk_out1 = ~clk_out1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int              m_edges, m_phase, m_ramp;
  logic [35:0]     m_q[$];
  logic [15:0]     m_re, m_im;
  bit              m_valid, m_ce, m_unf, m_ovf;
  logic [15:0]     cap_re[$], cap_im[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round half-up to a multiple of 4, divide, clamp to 16-bit signed.
  function automatic logic [15:0] ref_fmt(input logic [17:0] x);
    int v, s;
    v = int'($signed(x)) + 2;
    if (v >= 0) s = v / 4;
    else s = -((-v + 3) / 4);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic bit m_pop();
    return (m_phase == PhRun) && enable && (m_edges % DIV == 0) && (mode == 2'd0) &&
           (m_q.size() > 0);
  endfunction

  task automatic model_reset();
    m_edges = 0; m_phase = PhIdle; m_ramp = 0; m_q.delete();
    m_re = '0; m_im = '0; m_valid = 0; m_ce = 0; m_unf = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit tick, pop, flush, full, wr, ovf_set, unf_set;
    int lvl;
    logic [35:0] s;
    tick    = (m_edges % DIV) == 0;
    lvl     = m_q.size();
    full    = (lvl == DEPTH);
    flush   = (m_phase == PhIdle) || !enable;
    pop     = m_pop();
    wr      = in_valid && (!full || pop) && !flush;
    ovf_set = in_valid && full && !pop && !flush;
    unf_set = 0;
    m_ce    = (m_edges % DIV) == DIV - 1;
    m_valid = 0;
    if (m_phase == PhRun && enable && tick) begin
      m_valid = 1;
      case (mode)
        2'd0: begin
          if (pop) begin
            s = m_q.pop_front();
            m_re = ref_fmt(s[35:18]);
            m_im = ref_fmt(s[17:0]);
          end else begin
            m_re = '0; m_im = '0; unf_set = 1;
          end
        end
        2'd1: begin m_re = 16'h2000; m_im = 16'h0000; end
        2'd2: begin
          m_re = m_ramp[15:0];
          m_im = ~m_ramp[15:0];
          m_ramp = (m_ramp + 1) % 65536;
        end
        default: begin m_re = '0; m_im = '0; end
      endcase
    end
    if (flush) m_q.delete();
    else if (wr) m_q.push_back({in_re, in_im});
    case (m_phase)
      PhIdle:  if (enable) m_phase = PhPrime;
      PhPrime: begin
        if (!enable) m_phase = PhIdle;
        else if (lvl >= PLVL || mode != 2'd0) m_phase = PhRun;
      end
      default: if (!enable) m_phase = PhIdle;
    endcase
    if (!enable) m_ramp = 0;
    m_unf = (m_unf && !clear_flags) || unf_set;
    m_ovf = (m_ovf && !clear_flags) || ovf_set;
    m_edges++;
  endtask

  task automatic check_all();
    bit full;
    full = (m_q.size() == DEPTH);
    chk("duc_ce", duc_ce, m_ce);
    chk("dac_valid", dac_valid, m_valid);
    chk("dac_re", dac_re, m_re ^ {offset_bin, 15'b0});
    chk("dac_im", dac_im, m_im ^ {offset_bin, 15'b0});
    chk("underflow", underflow, m_unf);
    chk("overflow", overflow, m_ovf);
    chk("fifo_level", fifo_level, m_q.size());
    chk("in_ready", in_ready, !full || m_pop());
    if (dac_valid === 1'b1) begin
      cap_re.push_back(dac_re);
      cap_im.push_back(dac_im);
    end
  endtask

  task automatic step(input bit en, input logic [1:0] md, input bit v,
                      input logic [17:0] re, input logic [17:0] im);
    enable = en; mode = md; in_valid = v; in_re = re; in_im = im;
    #1 check_all();
    @(posedge clk_out1);
    model_step();
    @(negedge clk_out1);
  endtask

  task automatic cap_chk(input string tag, input int idx, input bit is_im,
                         input logic [15:0] exp);
    if (idx < cap_re.size()) chk(tag, is_im ? cap_im[idx] : cap_re[idx], exp);
    else chk({tag, "_strobe_count"}, cap_re.size(), idx + 1);
  endtask

  task automatic idle_steps(input int n, input bit en, input logic [1:0] md);
    for (int i = 0; i < n; i++) step(en, md, 1'b0, '0, '0);
  endtask

  initial begin
    logic [17:0] vre[4];
    logic [17:0] vim[4];
    vre = '{18'h00006, 18'h1FFFF, 18'h3FFFB, 18'h20000};
    vim = '{18'h00003, 18'h1FFFE, 18'h3FFFF, 18'h00007};

    model_reset();
    @(negedge clk_out1);
    @(negedge clk_out1);
    #1 check_all();
    rst = 1'b0;

    // Primed with no input: ticks only, no strobes, no underflow.
    cap_re.delete(); cap_im.delete();
    idle_steps(20, 1'b1, 2'd0);
    chk("t1_no_strobe", cap_re.size(), 0);
    chk("t1_underflow", underflow, 1'b0);

    // Rounding/saturation, then underflow on the fifth strobe.
    cap_re.delete(); cap_im.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b1, vre[i], vim[i]);
    idle_steps(22, 1'b1, 2'd0);
    cap_chk("t2_re0", 0, 1'b0, 16'h0002);
    cap_chk("t2_re1", 1, 1'b0, 16'h7FFF);
    cap_chk("t2_re2", 2, 1'b0, 16'hFFFF);
    cap_chk("t2_re3", 3, 1'b0, 16'h8000);
    cap_chk("t2_im1", 1, 1'b1, 16'h7FFF);
    cap_chk("t3_re4_zero", 4, 1'b0, 16'h0000);
    cap_chk("t3_im4_zero", 4, 1'b1, 16'h0000);
    chk("t3_underflow", underflow, 1'b1);
    clear_flags = 1'b1;
    step(1'b0, 2'd0, 1'b0, '0, '0);
    clear_flags = 1'b0;
    chk("t3_underflow_clr", underflow, 1'b0);

    // Same samples in offset binary.
    offset_bin = 1'b1;
    cap_re.delete(); cap_im.delete();
    step(1'b1, 2'd0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b1, vre[i], vim[i]);
    idle_steps(18, 1'b1, 2'd0);
    cap_chk("t2o_re0", 0, 1'b0, 16'h8002);
    cap_chk("t2o_re1", 1, 1'b0, 16'hFFFF);
    cap_chk("t2o_re2", 2, 1'b0, 16'h7FFF);
    cap_chk("t2o_re3", 3, 1'b0, 16'h0000);
    step(1'b0, 2'd0, 1'b0, '0, '0);
    offset_bin = 1'b0;

    // Sustained writes fill the FIFO and raise overflow.
    for (int i = 0; i < 24; i++) step(1'b1, 2'd0, 1'b1, 18'($urandom), 18'($urandom));
    chk("t4_overflow", overflow, 1'b1);
    clear_flags = 1'b1;
    step(1'b0, 2'd0, 1'b0, '0, '0);
    clear_flags = 1'b0;

    // Ramp, and restart after re-enable.
    cap_re.delete(); cap_im.delete();
    idle_steps(20, 1'b1, 2'd2);
    cap_chk("t5_re0", 0, 1'b0, 16'h0000);
    cap_chk("t5_re1", 1, 1'b0, 16'h0001);
    cap_chk("t5_re2", 2, 1'b0, 16'h0002);
    cap_chk("t5_im0", 0, 1'b1, 16'hFFFF);
    cap_chk("t5_im1", 1, 1'b1, 16'hFFFE);
    step(1'b0, 2'd2, 1'b0, '0, '0);
    cap_re.delete(); cap_im.delete();
    idle_steps(12, 1'b1, 2'd2);
    cap_chk("t5_restart", 0, 1'b0, 16'h0000);

    // Asynchronous reset mid-RUN with samples queued.
    step(1'b0, 2'd1, 1'b0, '0, '0);
    idle_steps(3, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 1'b1, 18'($urandom), 18'($urandom));
    chk("t6_level_before", fifo_level, 3);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    chk("t6_level", fifo_level, 0);
    chk("t6_valid", dac_valid, 1'b0);
    @(negedge clk_out1);
    #1 check_all();
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  md;
      logic [17:0] re, im;
      md = ($urandom % 4 == 0) ? 2'($urandom) : 2'd0;
      re = ($urandom % 8 == 0) ? {$urandom % 2 == 0, 17'h1FFFF ^ 17'($urandom % 4)}
                               : 18'($urandom);
      im = 18'($urandom);
      if ($urandom % 64 == 0) offset_bin = ~offset_bin;
      clear_flags = ($urandom % 16 == 0);
      step($urandom % 40 != 0, md, ($urandom % 3) != 0, re, im);
    end
    clear_flags = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
